input_conditioner: RTL

// - N-channel successor to button_parser: synchronise, debounce, edge-detect and classify

---
 rtl/input_conditioner.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/input_conditioner.sv
// input_conditioner: per-channel synchroniser, tick-sampled debouncer and
// press/release/long-press classifier for board buttons and switches.
// Optional auto-repeat is built when INPUT_COND_REPEAT_EN is defined.
// The debounced-fall pulse port is named release_pulse because "release"
// is a reserved word in the language.
module input_conditioner #(
  parameter int WIDTH          = 4,
  parameter int SYNC_STAGES    = 2,
  parameter int SAMPLE_CNT_MAX = 25000,
  parameter int PULSE_CNT_MAX  = 200,
  parameter int LONG_CNT_MAX   = 2000,
  parameter int REPEAT_CNT_MAX = 200
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  input  logic [WIDTH-1:0] enable,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] press,
  output logic [WIDTH-1:0] release_pulse,
  output logic [WIDTH-1:0] long_press,
  output logic [WIDTH-1:0] held
);

  localparam int SW = $clog2(SAMPLE_CNT_MAX + 1);
  localparam int PW = $clog2(PULSE_CNT_MAX + 1);
  localparam int LW = $clog2(LONG_CNT_MAX + 1);
  localparam logic [SW-1:0] S_LAST = SW'(SAMPLE_CNT_MAX - 1);
  localparam logic [PW-1:0] P_MAX  = PW'(PULSE_CNT_MAX);
  localparam logic [LW-1:0] L_MAX  = LW'(LONG_CNT_MAX);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PRESSED = 2'd1;
  localparam logic [1:0] ST_HELD    = 2'd2;
`ifdef INPUT_COND_REPEAT_EN
  localparam logic [1:0] ST_REPEAT  = 2'd3;
  localparam int RW = $clog2(REPEAT_CNT_MAX + 1);
  localparam logic [RW-1:0] R_MAX = RW'(REPEAT_CNT_MAX);
  logic [RW-1:0] rep_q [WIDTH];
  logic [RW-1:0] rep_d [WIDTH];
`endif

  logic [WIDTH-1:0] sync_q  [SYNC_STAGES];
  logic [WIDTH-1:0] sync_d  [SYNC_STAGES];
  logic [SW-1:0]    samp_q, samp_d;
  logic             tick;
  logic [PW-1:0]    cnt_q   [WIDTH];
  logic [PW-1:0]    cnt_d   [WIDTH];
  logic [LW-1:0]    hold_q  [WIDTH];
  logic [LW-1:0]    hold_d  [WIDTH];
  logic [1:0]       state_q [WIDTH];
  logic [1:0]       state_d [WIDTH];
  logic [WIDTH-1:0] level_q, level_d;

  // Next-state logic: sample tick, debounce counters, per-channel classifier.
  // level_q is loaded from cnt_d so a dropping tick lowers level on the same
  // edge that would complete hold_cnt; the release therefore beats long_press.
  always_comb begin
    tick   = (samp_q == S_LAST);
    samp_d = tick ? '0 : samp_q + SW'(1);
    sync_d[0] = in;
    for (int unsigned s = 1; s < SYNC_STAGES; s++) sync_d[s] = sync_q[s-1];
    level         = '0;
    press         = '0;
    release_pulse = '0;
    long_press    = '0;
    held          = '0;
    level_d       = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      cnt_d[i]   = cnt_q[i];
      hold_d[i]  = hold_q[i];
      state_d[i] = state_q[i];
`ifdef INPUT_COND_REPEAT_EN
      rep_d[i]   = rep_q[i];
`endif
      if (tick) begin
        if (sync_q[SYNC_STAGES-1][i])
          cnt_d[i] = (cnt_q[i] == P_MAX) ? P_MAX : cnt_q[i] + PW'(1);
        else
          cnt_d[i] = '0;
      end
      level_d[i] = (cnt_d[i] == P_MAX);
      level[i]   = level_q[i];

      case (state_q[i])
        ST_IDLE: begin
          hold_d[i] = '0;
          if (level_q[i]) begin
            press[i]   = 1'b1;
            state_d[i] = ST_PRESSED;
          end
        end
        ST_PRESSED: begin
          if (!level_q[i]) begin
            release_pulse[i] = 1'b1;
            state_d[i]       = ST_IDLE;
            hold_d[i]        = '0;
          end else if (hold_q[i] == L_MAX) begin
            long_press[i] = 1'b1;
            held[i]       = 1'b1;
`ifdef INPUT_COND_REPEAT_EN
            state_d[i]    = ST_REPEAT;
            rep_d[i]      = '0;
`else
            state_d[i]    = ST_HELD;
`endif
          end else if (tick) begin
            hold_d[i] = hold_q[i] + LW'(1);
          end
        end
        ST_HELD: begin
          if (!level_q[i]) begin
            release_pulse[i] = 1'b1;
            state_d[i]       = ST_IDLE;
            hold_d[i]        = '0;
          end else begin
            held[i] = 1'b1;
          end
        end
`ifdef INPUT_COND_REPEAT_EN
        ST_REPEAT: begin
          if (!level_q[i]) begin
            release_pulse[i] = 1'b1;
            state_d[i]       = ST_IDLE;
            hold_d[i]        = '0;
            rep_d[i]         = '0;
          end else begin
            held[i] = 1'b1;
            if (rep_q[i] == R_MAX) begin
              press[i] = 1'b1;
              rep_d[i] = tick ? RW'(1) : '0;
            end else if (tick) begin
              rep_d[i] = rep_q[i] + RW'(1);
            end
          end
        end
`endif
        default: state_d[i] = ST_IDLE;
      endcase

      if (!enable[i]) begin
        cnt_d[i]         = '0;
        hold_d[i]        = '0;
        state_d[i]       = ST_IDLE;
        level_d[i]       = 1'b0;
`ifdef INPUT_COND_REPEAT_EN
        rep_d[i]         = '0;
`endif
        level[i]         = 1'b0;
        press[i]         = 1'b0;
        release_pulse[i] = 1'b0;
        long_press[i]    = 1'b0;
        held[i]          = 1'b0;
      end
    end
  end

  // State registers, all cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      samp_q  <= '0;
      level_q <= '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        cnt_q[i]   <= '0;
        hold_q[i]  <= '0;
        state_q[i] <= ST_IDLE;
`ifdef INPUT_COND_REPEAT_EN
        rep_q[i]   <= '0;
`endif
      end
    end else begin
      for (int unsigned s = 0; s < SYNC_STAGES; s++) sync_q[s] <= sync_d[s];
      samp_q  <= samp_d;
      level_q <= level_d;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        cnt_q[i]   <= cnt_d[i];
        hold_q[i]  <= hold_d[i];
        state_q[i] <= state_d[i];
`ifdef INPUT_COND_REPEAT_EN
        rep_q[i]   <= rep_d[i];
`endif
      end
    end
  end

endmodule
